bram32bit_arbiter: RTL

//  Shares port A of the 32-bit, 4K-word byte-enabled dual-port BRAM between two requesters.

---
 rtl/bram32bit_arbiter_pkg.sv | 15 +
 rtl/bram32bit_arbiter_if.sv | 17 +
 rtl/bram32bit_arbiter_grant.sv | 47 ++++
 rtl/bram32bit_arbiter.sv | 72 +++++++
 4 files changed

// File: rtl/bram32bit_arbiter_pkg.sv
// Shared types for the BRAM port-A arbiter: bus widths, request payload, read owner.
package bram_arb_pkg;
    localparam int DW     = 32;
    localparam int BEW    = 4;
    localparam int AW_MAX = 16;

    typedef enum logic {OWN_REQ0 = 1'b0, OWN_REQ1 = 1'b1} owner_e;

    // Address field is sized for the widest supported BRAM; the top slices it back to AW.
    typedef struct packed {
        logic [BEW-1:0]    we;
        logic [AW_MAX-1:0] addr;
        logic [DW-1:0]     wdata;
    } bram_req_t;
endpackage

// File: rtl/bram32bit_arbiter_if.sv
// One requester's access channel into the BRAM arbiter (request payload out, ack/read data back).
interface bram32bit_arbiter_if
    import bram_arb_pkg::*;
#(
    parameter int AW = 12
);
    logic           req;
    logic [BEW-1:0] we;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic           ack;
    logic           rvalid;
    logic [DW-1:0]  rdata;

    modport master (output req, we, addr, wdata, input ack, rvalid, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rvalid, rdata);
endinterface

// File: rtl/bram32bit_arbiter_grant.sv
// Grant logic: fixed priority for requester 0 with a starvation counter for requester 1,
// or fair round-robin when BRAM_ARB_RR_EN is defined.
module bram_arb_grant
    import bram_arb_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic rstn,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
`ifdef BRAM_ARB_RR_EN
    owner_e last_gnt_q, last_gnt_d;

    always_comb begin
        gnt1       = req1 & (~req0 | (last_gnt_q == OWN_REQ0));
        gnt0       = req0 & ~gnt1;
        last_gnt_d = last_gnt_q;
        if (gnt1)      last_gnt_d = OWN_REQ1;
        else if (gnt0) last_gnt_d = OWN_REQ0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) last_gnt_q <= OWN_REQ1;
        else       last_gnt_q <= last_gnt_d;
    end
`else
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_cnt_q, starve_cnt_d;

    always_comb begin
        gnt1         = req1 & (~req0 | (starve_cnt_q == SMAX));
        gnt0         = req0 & ~gnt1;
        starve_cnt_d = starve_cnt_q;
        if (!req1 || gnt1)          starve_cnt_d = '0;
        else if (starve_cnt_q != SMAX) starve_cnt_d = starve_cnt_q + 4'd1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) starve_cnt_q <= '0;
        else       starve_cnt_q <= starve_cnt_d;
    end
`endif
endmodule

// File: rtl/bram32bit_arbiter.sv
// Shares BRAM port A between CPU (req0, priority) and DMA (req1); routes NOREG read data back.
// Define BRAM_ARB_RR_EN for round-robin arbitration instead of priority + starvation counter.
module bram32bit_arbiter
    import bram_arb_pkg::*;
#(
    parameter int AW         = 12,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    bram32bit_arbiter_if.slave    r0,
    bram32bit_arbiter_if.slave    r1,
    output logic                  bram_clken,
    output logic [BEW-1:0]        bram_we,
    output logic [AW-1:0]         bram_addr,
    output logic [DW-1:0]         bram_wdata,
    input  logic [DW-1:0]         bram_rdata
);
    logic      req0_v, req1_v, gnt0, gnt1;
    bram_req_t r0_req, r1_req, sel_req;
    logic      rd_pend_q, rd_pend_d;
    owner_e    rd_owner_q, rd_owner_d;
    logic      unused_addr_hi;

    // Requests are ignored while reset is asserted so nothing reaches the BRAM.
    always_comb begin
        req0_v = r0.req & rstn;
        req1_v = r1.req & rstn;
    end

    bram_arb_grant #(.STARVE_MAX(STARVE_MAX)) u_grant (
        .clk  (clk),
        .rstn (rstn),
        .req0 (req0_v),
        .req1 (req1_v),
        .gnt0 (gnt0),
        .gnt1 (gnt1)
    );

    assign r0_req = '{we: r0.we, addr: AW_MAX'(r0.addr), wdata: r0.wdata};
    assign r1_req = '{we: r1.we, addr: AW_MAX'(r1.addr), wdata: r1.wdata};
    assign unused_addr_hi = ^sel_req.addr[AW_MAX-1:AW];

    always_comb begin
        sel_req    = gnt1 ? r1_req : r0_req;
        bram_clken = gnt0 | gnt1;
        bram_we    = bram_clken ? sel_req.we : '0;
        bram_addr  = sel_req.addr[AW-1:0];
        bram_wdata = sel_req.wdata;
        rd_pend_d  = bram_clken && (sel_req.we == '0);
        rd_owner_d = rd_owner_q;
        if (rd_pend_d) rd_owner_d = gnt1 ? OWN_REQ1 : OWN_REQ0;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_pend_q  <= 1'b0;
            rd_owner_q <= OWN_REQ0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            rd_owner_q <= rd_owner_d;
        end
    end

    // BRAM output holds when clken drops, so rdata is only qualified by rvalid.
    assign r0.ack    = gnt0;
    assign r1.ack    = gnt1;
    assign r0.rvalid = rd_pend_q && (rd_owner_q == OWN_REQ0);
    assign r1.rvalid = rd_pend_q && (rd_owner_q == OWN_REQ1);
    assign r0.rdata  = bram_rdata;
    assign r1.rdata  = bram_rdata;
endmodule
